rng_range: RTL and testbench



---
 rtl/rng_range.sv | 140 ++++++++++++++
 tb/tb_rng_range.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/rng_range.sv
// rng_range: Fibonacci-LFSR random source with rejection sampling into
// [0, MAX_VALUE-1], valid/ready output handshake and runtime reseeding.
// Optional build macro RNG_NO_REPEAT_EN: also rejects a candidate equal to
// the previously accepted sample (history survives seed_load, not rst_n).
module rng_range #(
  parameter int          LFSR_WIDTH = 16,
  parameter int          MAX_VALUE  = 18,
  parameter int          OUT_WIDTH  = 5,
  parameter logic [31:0] SEED       = 32'd1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  seed_load,
  input  logic [LFSR_WIDTH-1:0] seed_in,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [OUT_WIDTH-1:0]  random_value,
  output logic [7:0]            reject_cnt
);

  typedef enum logic {FILL, HOLD} state_t;

  localparam logic [LFSR_WIDTH-1:0] SEED_RAW = SEED[LFSR_WIDTH-1:0];
  localparam logic [LFSR_WIDTH-1:0] ONE      = {{(LFSR_WIDTH-1){1'b0}}, 1'b1};
  // A zero seed would lock the LFSR, so it is promoted to 1.
  localparam logic [LFSR_WIDTH-1:0] SEED_EFF = (SEED_RAW == '0) ? ONE : SEED_RAW;
  // One extra bit so MAX_VALUE == 2^OUT_WIDTH is representable.
  localparam logic [OUT_WIDTH:0]    MAX_V    = (OUT_WIDTH+1)'(MAX_VALUE);

  state_t                  state_q;
  logic [LFSR_WIDTH-1:0]   lfsr_q;
  logic [LFSR_WIDTH-1:0]   lfsr_d;
  logic [LFSR_WIDTH-1:0]   seed_fix;
  logic                    out_valid_q;
  logic [OUT_WIDTH-1:0]    random_value_q;
  logic [7:0]              reject_cnt_q;
  logic                    fb;
  logic [OUT_WIDTH-1:0]    cand;
  logic                    in_range;
  logic                    repeat_hit;
  logic                    accept;

  // Parameter legality is enforced at elaboration time.
  if (OUT_WIDTH > LFSR_WIDTH) begin : g_bad_out_width
    $error("rng_range: OUT_WIDTH must not exceed LFSR_WIDTH");
  end
  if (MAX_VALUE < 2 || $clog2(MAX_VALUE) > OUT_WIDTH) begin : g_bad_max
    $error("rng_range: MAX_VALUE must be in [2, 2^OUT_WIDTH]");
  end

  // Maximal-length feedback taps (1-indexed tap k is bit k-1).
  if (LFSR_WIDTH == 8) begin : g_w8
    assign fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  end else if (LFSR_WIDTH == 16) begin : g_w16
    assign fb = lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3];
  end else if (LFSR_WIDTH == 24) begin : g_w24
    assign fb = lfsr_q[23] ^ lfsr_q[22] ^ lfsr_q[21] ^ lfsr_q[16];
  end else if (LFSR_WIDTH == 32) begin : g_w32
    assign fb = lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0];
  end else begin : g_bad_width
    $error("rng_range: LFSR_WIDTH must be 8, 16, 24 or 32");
    assign fb = 1'b0;
  end

  assign lfsr_d   = {lfsr_q[LFSR_WIDTH-2:0], fb};
  assign seed_fix = (seed_in == '0) ? ONE : seed_in;
  // The candidate is taken from the register before this cycle's step.
  assign cand     = lfsr_q[OUT_WIDTH-1:0];
  assign in_range = ({1'b0, cand} < MAX_V);

`ifdef RNG_NO_REPEAT_EN
  logic [OUT_WIDTH-1:0] last_value_q;
  logic                 last_valid_q;
  assign repeat_hit = last_valid_q && (cand == last_value_q);

  // Remember the most recently accepted sample; only rst_n clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_value_q <= '0;
      last_valid_q <= 1'b0;
    end else if (!seed_load && state_q == FILL && enable && accept) begin
      last_value_q <= cand;
      last_valid_q <= 1'b1;
    end
  end
`else
  assign repeat_hit = 1'b0;
`endif

  assign accept = in_range && !repeat_hit;

  // Sampling FSM: FILL evaluates candidates, HOLD presents one until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= FILL;
      lfsr_q         <= SEED_EFF;
      out_valid_q    <= 1'b0;
      random_value_q <= '0;
      reject_cnt_q   <= '0;
    end else if (seed_load) begin
      // Reseed wins over everything; any held sample is dropped.
      state_q      <= FILL;
      lfsr_q       <= seed_fix;
      out_valid_q  <= 1'b0;
      reject_cnt_q <= '0;
    end else begin
      if (enable) begin
        lfsr_q <= lfsr_d;
      end
      case (state_q)
        FILL: begin
          if (enable) begin
            if (accept) begin
              random_value_q <= cand;
              out_valid_q    <= 1'b1;
              state_q        <= HOLD;
            end else if (reject_cnt_q != 8'hFF) begin
              reject_cnt_q <= reject_cnt_q + 8'd1;
            end
          end
        end
        HOLD: begin
          // The handshake does not depend on enable.
          if (out_ready) begin
            out_valid_q  <= 1'b0;
            reject_cnt_q <= '0;
            state_q      <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign out_valid    = out_valid_q;
  assign random_value = random_value_q;
  assign reject_cnt   = reject_cnt_q;

endmodule

// File: tb/tb_rng_range.sv
// Self-checking bench for rng_range (8-bit LFSR, MAX_VALUE=18, OUT_WIDTH=5).
module tb_rng_range;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic       seed_load = 1'b0;
  logic [7:0] seed_in = 8'h00;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [4:0] random_value;
  logic [7:0] reject_cnt;

  int total = 0;
  int bad   = 0;

`ifdef RNG_NO_REPEAT_EN
  localparam bit NO_REPEAT = 1'b1;
`else
  localparam bit NO_REPEAT = 1'b0;
`endif

  // Reference model state (transaction level, arithmetic form).
  int m_lfsr;
  bit m_valid;
  int m_val;
  int m_rej;
  int m_last;
  bit m_lv;

  always #5 clk = ~clk;

  rng_range #(
    .LFSR_WIDTH(8),
    .MAX_VALUE (18),
    .OUT_WIDTH (5),
    .SEED      (32'd1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .seed_load   (seed_load),
    .seed_in     (seed_in),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .random_value(random_value),
    .reject_cnt  (reject_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Next LFSR state: shift left, feed back parity of taps 8,6,5,4 (mask 0xB8).
  function automatic int m_next(input int s);
    int p;
    p = 0;
    for (int b = 0; b < 8; b++) if (((s & 'hB8) >> b) & 1) p ^= 1;
    return ((s * 2) + p) % 256;
  endfunction

  task automatic m_reset();
    m_lfsr = 1; m_valid = 0; m_val = 0; m_rej = 0; m_last = 0; m_lv = 0;
  endtask

  task automatic m_step(input bit en, input bit ld, input int sd, input bit rdy);
    int c;
    if (ld) begin
      m_lfsr  = (sd == 0) ? 1 : sd;
      m_valid = 0;
      m_rej   = 0;
    end else begin
      c = m_lfsr % 32;
      if (en) m_lfsr = m_next(m_lfsr);
      if (!m_valid) begin
        if (en) begin
          if (c < 18 && !(NO_REPEAT && m_lv && c == m_last)) begin
            m_val = c; m_valid = 1; m_last = c; m_lv = 1;
          end else if (m_rej < 255) begin
            m_rej++;
          end
        end
      end else if (rdy) begin
        $display("sample value=%0d rejects=%0d", m_val, m_rej);
        m_valid = 0;
        m_rej   = 0;
      end
    end
  endtask

  // One clock: drive, advance model on the edge, compare 1 ns later.
  task automatic cycle(input bit en, input bit ld, input logic [7:0] sd, input bit rdy);
    enable = en; seed_load = ld; seed_in = sd; out_ready = rdy;
    @(posedge clk);
    m_step(en, ld, int'(sd), rdy);
    #1;
    seed_load = 1'b0;
    chk("m_valid", 32'(out_valid), 32'(m_valid));
    chk("m_value", 32'(random_value), 32'(m_val));
    chk("m_rej", 32'(reject_cnt), 32'(m_rej));
  endtask

  initial begin
    bit seen[256];
    int distinct;
    int dups;
    int k;

    // Reset values
    #2 rst_n = 1'b0;
    #2;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_value", 32'(random_value), 0);
    chk("rst_rej", 32'(reject_cnt), 0);
    chk("rst_lfsr", 32'(dut.lfsr_q), 1);
    m_reset();
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    // First sample is 1, next is 4
    cycle(1, 0, 8'h00, 1);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_value", 32'(random_value), 1);
    chk("t1_rej", 32'(reject_cnt), 0);
    cycle(1, 0, 8'h00, 1);
    chk("t1_bubble", 32'(out_valid), 0);
    cycle(1, 0, 8'h00, 1);
    chk("t1_value2", 32'(random_value), 4);
    chk("t1_valid2", 32'(out_valid), 1);

    // Reseed 0x1F: five rejections then 13
    cycle(0, 1, 8'h1F, 0);
    chk("t2_load_valid", 32'(out_valid), 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 8'h00, 0);
      chk("t2_rej_valid", 32'(out_valid), 0);
      chk("t2_rej_cnt", 32'(reject_cnt), 32'(i + 1));
    end
    cycle(1, 0, 8'h00, 0);
    chk("t2_value", 32'(random_value), 13);
    chk("t2_valid", 32'(out_valid), 1);
    chk("t2_rej", 32'(reject_cnt), 5);

    // Back-pressure holds the sample
    for (int i = 0; i < 10; i++) begin
      cycle(1, 0, 8'h00, 0);
      chk("t3_hold_value", 32'(random_value), 13);
      chk("t3_hold_valid", 32'(out_valid), 1);
    end
    cycle(1, 0, 8'h00, 1);
    chk("t3_taken_valid", 32'(out_valid), 0);
    chk("t3_taken_rej", 32'(reject_cnt), 0);

    // Zero seed becomes 1
    cycle(0, 1, 8'h00, 0);
    chk("t4_seed0_lfsr", 32'(dut.lfsr_q), 1);
    cycle(1, 0, 8'h00, 1);
    chk("t4_value", 32'(random_value), 1);
    chk("t4_valid", 32'(out_valid), 1);

    // Full-period sweep from state 1
    cycle(0, 1, 8'h01, 0);
    distinct = 0; dups = 0;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 0; i < 255; i++) begin
      if (seen[dut.lfsr_q]) dups++;
      else distinct++;
      seen[dut.lfsr_q] = 1'b1;
      chk("t4_sweep_lfsr", 32'(dut.lfsr_q), 32'(m_lfsr));
      cycle(1, 0, 8'h00, 1);
    end
    chk("t4_sweep_dups", 32'(dups), 0);
    chk("t4_sweep_distinct", 32'(distinct), 255);
    chk("t4_sweep_zero", 32'(seen[0]), 0);
    chk("t4_sweep_wrap", 32'(dut.lfsr_q), 1);

    // enable=0 freezes FILL
    cycle(0, 1, 8'h1F, 0);
    cycle(1, 0, 8'h00, 0);
    cycle(1, 0, 8'h00, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 8'h00, 1);
      chk("t5_frz_lfsr", 32'(dut.lfsr_q), 32'h7D);
      chk("t5_frz_rej", 32'(reject_cnt), 2);
      chk("t5_frz_valid", 32'(out_valid), 0);
    end

    // Async reset during HOLD
    cycle(0, 1, 8'h01, 0);
    k = 0;
    while (!m_valid && k < 20) begin
      cycle(1, 0, 8'h00, 0);
      k++;
    end
    chk("t5_hold_valid", 32'(out_valid), 1);
    rst_n = 1'b0;
    #2;
    chk("t5_async_valid", 32'(out_valid), 0);
    m_reset();
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    // Repeat filter across reseed
    cycle(1, 0, 8'h00, 1);
    chk("t6_first", 32'(random_value), 1);
    cycle(1, 0, 8'h00, 1);
    cycle(0, 1, 8'h01, 0);
    cycle(1, 0, 8'h00, 0);
    if (NO_REPEAT) begin
      chk("t6_nr_rej", 32'(reject_cnt), 1);
      chk("t6_nr_valid", 32'(out_valid), 0);
      cycle(1, 0, 8'h00, 0);
      chk("t6_nr_value", 32'(random_value), 2);
      chk("t6_nr_valid2", 32'(out_valid), 1);
    end else begin
      chk("t6_rep_value", 32'(random_value), 1);
      chk("t6_rep_valid", 32'(out_valid), 1);
      chk("t6_rep_rej", 32'(reject_cnt), 0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      bit en, ld, rdy;
      logic [7:0] sd;
      en  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 1) != 0);
      ld  = ($urandom_range(0, 31) == 0);
      sd  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      cycle(en, ld, sd, rdy);
      if (out_valid === 1'b1) chk("rand_range", 32'(random_value < 5'd18), 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
